ahb_input_port: RTL and testbench
=================================

# ahb_input_port

AHB-Lite responder that gives the Cortex-M0 the joystick and push-button state. It takes the four joystick lines and four KEY buttons after the board wrapper has inverted them to active-high. Each line is synchronised and debounced. Debounced levels and sticky press events are exposed as memory-mapped registers, with an optional interrupt. The block sits on the AHB-Lite bus beside the VGA peripheral inside the system top.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required before a debounced level changes (10 ms at 50 MHz); must be ≥ 2
- HCLK  input  1  system clock, all state on rising edge
- HRESET  input  1  synchronous, active-high reset
- HSEL  input  1  slave select
- HADDR  input  32  address; bits [3:2] decode registers
- HTRANS  input  2  transfer type; HTRANS[1]=1 is a valid transfer
- HWRITE  input  1  write when 1
- HSIZE  input  3  ignored; all accesses treated as 32-bit
- HWDATA  input  32  write data (data phase)
- HREADY  input  1  bus ready
- HRDATA  output  32  read data
- HREADYOUT  output  1  constant 1 (zero wait states)
- HRESP  output  1  constant 0 (OKAY)
- joystick  input  4  active-high joystick lines, asynchronous; bit 0 up, 1 down, 2 left, 3 right
- buttons  input  4  active-high KEY lines, asynchronous
- IRQ  output  1  level interrupt (see Configuration)

## Operation
- Raw vector in[7:0] = {buttons, joystick}.
- Each bit passes through a 2-flop synchroniser, then through a per-bit debouncer.
- Each debouncer has a counter of width clog2(DEBOUNCE_CYCLES).
  - If the synchronised value differs from the debounced value, the counter increments.
  - When the counter reads DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced bit takes the new value and the counter returns to 0.
  - Any cycle where the synchronised value equals the debounced value clears the counter.
- Press event: a debounced 0→1 transition sets PRESS[i]. A 1→0 transition sets nothing.
- Register map (HADDR[3:2]):
  - 0x0 STATUS, RO: [7:0] debounced levels, upper bits 0.
  - 0x4 PRESS, sticky: write-1-to-clear on [7:0]. Reads do not clear it.
  - 0x8 IRQ_EN, RW: [7:0].
  - 0xC reserved: reads 0, writes ignored.
- Writes to STATUS are ignored. HWDATA bits [31:8] are ignored.
- AHB address phase is captured when HSEL & HREADY & HTRANS[1]: register HADDR[3:2], HWRITE and a valid flag.
  - Write data is applied at the end of the data phase, i.e. on the next edge using HWDATA.
  - Read data is driven combinationally from the captured address during the data phase. It is 0 when no valid read is pending.
- Simultaneous PRESS set from the debouncer and W1C of the same bit: the set wins, and the bit stays 1.
- Back-to-back transfers are supported. A write followed immediately by a read of the same register returns the post-write value.

## Timing
- Reset values: HRDATA 0, HREADYOUT 1, HRESP 0, IRQ 0. Synchronisers, debounced levels, counters, PRESS and IRQ_EN are all 0.
- Reset asserted mid-debounce or mid-transfer discards all state on the next edge. A pending write is not applied.
- Pin-to-STATUS latency: for a level stable from the first sampling edge E, STATUS updates on edge E+DEBOUNCE_CYCLES+1. PRESS sets on the same edge.
- A pulse stable for fewer than DEBOUNCE_CYCLES synchronised samples never changes STATUS.
- IRQ is combinational from registers, so it is visible in the cycle after the PRESS/IRQ_EN edge that enables it. It deasserts the cycle after the clearing write's data-phase edge.
- Reads have zero wait states; HRDATA is valid in the data phase of the transfer.

## Configuration
- INPUT_IRQ_EN defined:
  - IRQ_EN register is implemented.
  - IRQ = |(PRESS[7:0] & IRQ_EN[7:0]).
- INPUT_IRQ_EN undefined:
  - IRQ is tied to 0.
  - 0x8 reads 0 and writes to it are ignored.
  - No IRQ_EN flops are synthesised.
  - PRESS behaviour is unchanged.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert HRESET for 2 cycles with joystick=4'hF → STATUS=0, PRESS=0, IRQ=0, HREADYOUT=1, HRESP=0 on the first read.
- Debounce: raise joystick[0] and hold → STATUS reads 0x01 starting exactly 5 edges after the first sampling edge; PRESS=0x01.
- Glitch rejection: buttons[2] high for 3 cycles, then low → STATUS and PRESS stay 0 indefinitely.
- W1C and collision: with PRESS=0x11, write 0x01 to 0x4 → PRESS reads 0x10. Then time a W1C of bit 4 onto the edge where a new buttons[0] press sets bit 4 → bit 4 stays 1.
- Interrupt (INPUT_IRQ_EN): IRQ_EN=0x08 and joystick[3] press → IRQ rises. W1C 0x08 → IRQ falls one cycle later. Without the macro, the same stimulus gives IRQ=0 and IRQ_EN reads 0.
- Bus: back-to-back write 0xFF to 0x8 then read 0x8 → 0xFF. Read of 0xC returns 0. An idle HTRANS=0 with HSEL=1 changes nothing.

Source files
------------

// File: rtl/ahb_input_port.sv
// AHB-Lite responder exposing debounced joystick/KEY levels and sticky press events.
// Define INPUT_IRQ_EN to implement the IRQ_EN register and the level interrupt.
module ahb_input_port #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [3:0]  joystick,
  input  logic [3:0]  buttons,
  output logic        IRQ
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_PRESS  = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd2;

  logic [7:0]         raw;
  logic [7:0]         sync1;
  logic [7:0]         sync2;
  logic [7:0]         level;
  logic [7:0]         level_nxt;
  logic [7:0][CW-1:0] cnt;
  logic [7:0][CW-1:0] cnt_nxt;
  logic [7:0]         press;
  logic [7:0]         press_set;
  logic [7:0]         press_clr;
  logic [7:0]         irq_en;

  logic       ph_valid;
  logic       ph_write;
  logic [1:0] ph_addr;
  logic       addr_ok;
  logic       wr_active;

  assign raw = {buttons, joystick};

  // A debounced bit flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    level_nxt = level;
    cnt_nxt   = '0;
    for (int i = 0; i < 8; i++) begin
      if (sync2[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press_set = level_nxt & ~level;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= level_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign addr_ok   = HSEL & HREADY & HTRANS[1];
  assign wr_active = ph_valid & ph_write;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ph_valid <= 1'b0;
      ph_write <= 1'b0;
      ph_addr  <= '0;
    end else begin
      ph_valid <= addr_ok;
      if (addr_ok) begin
        ph_write <= HWRITE;
        ph_addr  <= HADDR[3:2];
      end
    end
  end

  assign press_clr = (wr_active && ph_addr == ADDR_PRESS) ? HWDATA[7:0] : 8'h00;

  // A new press landing on the same edge as its W1C must survive.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      press <= '0;
    end else begin
      press <= (press & ~press_clr) | press_set;
    end
  end

`ifdef INPUT_IRQ_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_en <= '0;
    end else if (wr_active && ph_addr == ADDR_IRQ_EN) begin
      irq_en <= HWDATA[7:0];
    end
  end

  assign IRQ = |(press & irq_en);
`else
  assign irq_en = 8'h00;
  assign IRQ    = 1'b0;
`endif

  always_comb begin
    HRDATA = '0;
    if (ph_valid && !ph_write) begin
      case (ph_addr)
        ADDR_STATUS: HRDATA = {24'h0, level};
        ADDR_PRESS:  HRDATA = {24'h0, press};
        ADDR_IRQ_EN: HRDATA = {24'h0, irq_en};
        default:     HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

endmodule

// File: tb/tb_ahb_input_port.sv
// Bench for ahb_input_port: directed scenarios plus randomized traffic against a window-based model.
// Expectations for the interrupt path follow INPUT_IRQ_EN.
module tb_ahb_input_port;
  localparam int D = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  joystick;
  logic [3:0]  buttons;
  logic        IRQ;

  int checks   = 0;
  int failures = 0;

  ahb_input_port #(.DEBOUNCE_CYCLES(D)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .joystick(joystick), .buttons(buttons), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

`ifdef INPUT_IRQ_EN
  localparam bit IRQ_IMPL = 1'b1;
`else
  localparam bit IRQ_IMPL = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a bit flips when the last D synchronised samples (raw delayed by 2) all differ from it.
  logic [7:0] hist [$];
  logic [7:0] m_level, m_press, m_irq_en;
  logic       m_valid, m_write;
  logic [1:0] m_addr;
  bit         model_live = 1'b0;

  always @(posedge HCLK) begin
    logic [7:0] nl, set_m, clr, smp;
    bit         all_diff;
    if (HRESET) begin
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_front(8'h00);
      m_level = 8'h00; m_press = 8'h00; m_irq_en = 8'h00;
      m_valid = 1'b0;  m_write = 1'b0;  m_addr = 2'd0;
      model_live = 1'b1;
    end else if (model_live) begin
      hist.push_front({buttons, joystick});
      while (hist.size() > D + 2) void'(hist.pop_back());
      nl = m_level;
      for (int i = 0; i < 8; i++) begin
        all_diff = 1'b1;
        for (int j = 2; j <= D + 1; j++) begin
          smp = hist[j];
          if (smp[i] == m_level[i]) all_diff = 1'b0;
        end
        if (all_diff) nl[i] = ~m_level[i];
      end
      set_m = nl & ~m_level;
      clr   = 8'h00;
      if (m_valid && m_write && m_addr == 2'd1) clr = HWDATA[7:0];
      if (IRQ_IMPL && m_valid && m_write && m_addr == 2'd2) m_irq_en = HWDATA[7:0];
      m_press = (m_press & ~clr) | set_m;
      m_level = nl;
      m_valid = HSEL && HREADY && HTRANS[1];
      if (m_valid) begin
        m_addr  = HADDR[3:2];
        m_write = HWRITE;
      end
    end
  end

  function automatic logic [31:0] exp_rdata();
    if (!m_valid || m_write) return 32'h0;
    case (m_addr)
      2'd0:    return {24'h0, m_level};
      2'd1:    return {24'h0, m_press};
      2'd2:    return {24'h0, m_irq_en};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge HCLK) begin
    if (model_live) begin
      chk("hrdata_model", HRDATA, exp_rdata());
      chk("irq_model", {31'h0, IRQ}, {31'h0, |(m_press & m_irq_en)});
      chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("hresp", {31'h0, HRESP}, 32'h0);
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    tick(); addr_phase(a, 1'b1);
    tick(); HWDATA = d; drive_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    tick(); addr_phase(a, 1'b0);
    tick(); drive_idle();
    d = HRDATA;
  endtask

  task automatic do_reset(input int n);
    tick(); HRESET = 1'b1;
    repeat (n) tick();
    HRESET = 1'b0;
  endtask

  logic [31:0] rd;
  logic [7:0]  rin;

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HSIZE = 3'b010; HWDATA = 32'h0;
    joystick = 4'hF; buttons = 4'h0;
    drive_idle();

    // Reset with joystick held high: nothing visible yet.
    tick(); tick(); HRESET = 1'b0;
    bus_read(32'h0, rd);
    chk("reset_status", rd, 32'h0);
    chk("reset_irq", {31'h0, IRQ}, 32'h0);
    chk("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("reset_hresp", {31'h0, HRESP}, 32'h0);
    bus_read(32'h4, rd);
    chk("reset_press", rd, 32'h0);
    joystick = 4'h0;
    do_reset(2);

    // Debounce latency: continuous STATUS reads, first sampling edge is the next one.
    joystick = 4'h1;
    addr_phase(32'h0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("debounce_latency", HRDATA, (n >= D + 1) ? 32'h1 : 32'h0);
    end
    drive_idle();
    bus_read(32'h4, rd);
    chk("debounce_press", rd, 32'h1);

    // Glitch rejection: 3 samples high is one short.
    tick(); buttons = 4'b0100;
    tick(); tick(); tick(); buttons = 4'b0000;
    repeat (12) tick();
    bus_read(32'h0, rd);
    chk("glitch_status", rd, 32'h1);
    bus_read(32'h4, rd);
    chk("glitch_press", rd, 32'h1);

    // W1C
    tick(); buttons = 4'b0001;
    repeat (8) tick();
    bus_read(32'h4, rd);
    chk("press_0x11", rd, 32'h11);
    bus_write(32'h4, 32'h1);
    bus_read(32'h4, rd);
    chk("w1c_bit0", rd, 32'h10);
    tick(); buttons = 4'b0000;
    repeat (8) tick();
    bus_write(32'h4, 32'h10);
    bus_read(32'h4, rd);
    chk("w1c_bit4", rd, 32'h0);

    // Collision: W1C data-phase edge coincides with the debounced rise of buttons[0].
    tick(); buttons = 4'b0001;
    repeat (4) tick();
    addr_phase(32'h4, 1'b1);
    tick(); HWDATA = 32'h10; drive_idle();
    tick();
    bus_read(32'h4, rd);
    chk("collision_set_wins", rd, 32'h10);
    bus_read(32'h0, rd);
    chk("collision_status", rd, 32'h11);

    // Interrupt
    bus_write(32'h8, 32'h8);
    tick(); joystick = 4'b1001;
    repeat (8) tick();
    chk("irq_rise", {31'h0, IRQ}, {31'h0, IRQ_IMPL});
    bus_read(32'h8, rd);
    chk("irq_en_read", rd, IRQ_IMPL ? 32'h8 : 32'h0);
    tick(); addr_phase(32'h4, 1'b1);
    tick(); HWDATA = 32'h8; drive_idle();
    chk("irq_before_clear", {31'h0, IRQ}, {31'h0, IRQ_IMPL});
    tick();
    chk("irq_after_clear", {31'h0, IRQ}, 32'h0);

    // Back-to-back write then read of IRQ_EN.
    tick(); addr_phase(32'h8, 1'b1);
    tick(); HWDATA = 32'hFF; addr_phase(32'h8, 1'b0);
    tick(); drive_idle();
    chk("b2b_irq_en", HRDATA, IRQ_IMPL ? 32'hFF : 32'h0);

    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'hC, rd);
    chk("reserved_read", rd, 32'h0);
    bus_write(32'h0, 32'h0);
    bus_read(32'h0, rd);
    chk("status_ro", rd, 32'h19);

    // Idle and busy transfers with HSEL high must not write.
    tick(); HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h4;
    tick(); HWDATA = 32'hFF; HTRANS = 2'b01;
    tick(); HWDATA = 32'hFF; drive_idle();
    tick();
    bus_read(32'h4, rd);
    chk("idle_no_write", rd, 32'h10);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      tick();
      HRESET = ($urandom_range(0, 599) == 0);
      rin = {buttons, joystick};
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) rin[b] = ~rin[b];
      end
      {buttons, joystick} = rin;
      HSEL   = 1'($urandom_range(0, 1));
      HTRANS = 2'($urandom_range(0, 3));
      HADDR  = $urandom;
      HWRITE = 1'($urandom_range(0, 1));
      HWDATA = $urandom;
      HREADY = ($urandom_range(0, 9) != 0);
    end

    HRESET = 1'b0; HREADY = 1'b1;
    drive_idle();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
